// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the program/data RAM arbiter.
// Policy macro used by ram_arb_pick: RAM_ARB_RR_EN (round-robin when defined).
package ram_arb_pkg;

    localparam int unsigned AW_DEF = 8;
    localparam int unsigned DW_DEF = 8;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_LSU   = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_e;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner selection between fetch (0) and load/store (1) requests.
// RAM_ARB_RR_EN defined: ties go to the requester not last granted; else fetch wins.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic winner_o,
    output logic valid_o
);

    always_comb begin
        valid_o = req0_i | req1_i;
`ifdef RAM_ARB_RR_EN
        if (req0_i && req1_i) begin
            winner_o = ~last_i;
        end else begin
            winner_o = req1_i ? REQ_LSU : REQ_FETCH;
        end
`else
        winner_o = (!req0_i && req1_i) ? REQ_LSU : REQ_FETCH;
`endif
    end

`ifndef RAM_ARB_RR_EN
    logic unused_last;
    assign unused_last = last_i;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for the single-port program/data RAM: IDLE -> ACCESS -> ACK.
// Tie policy chosen by RAM_ARB_RR_EN inside ram_arb_pick (fixed priority when undefined).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          busy,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          ram_ce_q, ram_ce_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          busy_q, busy_d;

    logic          pick_winner;
    logic          pick_valid;

    // owner_q doubles as the round-robin "last granted" pointer: both update on every grant
    ram_arb_pick u_pick (
        .req0_i   (req0),
        .req1_i   (req1),
        .last_i   (owner_q),
        .winner_o (pick_winner),
        .valid_o  (pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= REQ_FETCH;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ram_ce_q    <= ram_ce_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ram_ce_d    = ram_ce_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        busy_d      = busy_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d     = pick_winner;
                    ram_ce_d    = 1'b1;
                    ram_we_d    = pick_winner ? we1 : we0;
                    ram_addr_d  = pick_winner ? addr1 : addr0;
                    ram_wdata_d = pick_winner ? wdata1 : wdata0;
                    busy_d      = 1'b1;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                ram_ce_d = 1'b0;
                ram_we_d = 1'b0;
                if (!ram_we_q) begin
                    if (owner_q == REQ_LSU) begin
                        rdata1_d = ram_rdata;
                    end else begin
                        rdata0_d = ram_rdata;
                    end
                end
                ack1_d  = (owner_q == REQ_LSU);
                ack0_d  = (owner_q == REQ_FETCH);
                state_d = ACK;
            end
            ACK: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign busy      = busy_q;
    assign ram_ce    = ram_ce_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port 256x8 program/data RAM between the instruction-fetch unit (requester 0) and the load/store unit (requester 1). It accepts per-requester request/ack handshakes, selects one winner, drives the RAM's ce/we/addr/data_in for exactly one cycle, and returns registered read data. It sits between the CPU control path and the RAM instance; the RAM's read port is combinational, so the arbiter registers it.

## Interface
- AW, 8, address width (RAM depth 2**AW)
- DW, 8, data width
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request; held high with fields stable until matching ack
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  access address
- wdata0 / wdata1  in  DW  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DW  read data, valid while ackN high, held until that requester's next ack
- busy  out  1  high in ACCESS and ACK states
- ram_ce  out  1  RAM chip enable
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM combinational read data

## Operation
- FSM states: IDLE, ACCESS, ACK.
- IDLE: if any req high, pick winner, latch owner, we, addr and wdata into RAM output registers; next state ACCESS. Else stay.
- ACCESS: ram_ce=1, ram_we=latched we. Write commits in RAM on the edge ending ACCESS. For reads, ram_rdata is captured into rdata<owner> on that edge. Next state ACK.
- ACK: ack<owner>=1 for this cycle only; ram_ce=0, ram_we=0. No arbitration in ACK. Next state IDLE.
- Requester lowers req (or presents a new request) on the edge ending its ack cycle; req sampled only in IDLE.
- A requester whose req drops before being granted is simply not served; a req dropped after grant does not abort the access.
- Write access: rdataN unchanged.
- Priority default: requester 0 (fetch) always wins a simultaneous request.
- ram_addr/ram_wdata hold last value outside ACCESS; only ram_ce/ram_we gate the access.

## Timing
- Reset values: state IDLE; ack0=ack1=0; rdata0=rdata1=0; busy=0; ram_ce=0; ram_we=0; ram_addr=0; ram_wdata=0; RR pointer=0.
- Latency: req high before edge k (IDLE) -> ACCESS cycle k+1 -> ackN in cycle k+2. Throughput one access per 3 cycles.
- All outputs registered; no combinational path from req to ram_* or ack.
- Reset asserted mid-ACCESS: ram_ce/ram_we drop immediately (async); a write in flight may not commit; no ack issued.
- Requests arriving during ACCESS/ACK wait; ungranted requester is served in the next IDLE.

## Configuration
- RAM_ARB_RR_EN defined: round-robin. One-bit pointer records last owner; on simultaneous req, the requester not last granted wins. Pointer updates on every grant; reset value 0 means requester 1 wins the first tie... pointer=0 denotes "requester 0 last granted", so first tie goes to requester 1.
- Undefined: fixed priority, requester 0 always wins ties; pointer logic absent.

## Structure
- Package ram_arb_pkg: state enum (IDLE, ACCESS, ACK), requester ID constants REQ_FETCH=0, REQ_LSU=1, default AW/DW localparams.
- One combinational sub-module ram_arb_pick: inputs req0, req1, last-owner bit; output winner and valid; macro selects policy inside it.

## Test plan
- Reset then req0 read addr 0x10 (RAM preloaded 0xA5) -> ram_ce high exactly one cycle, ack0 two cycles after request edge, rdata0=0xA5.
- req1 write addr 0x20 data 0x3C, then req1 read 0x20 -> second ack1 with rdata1=0x3C; rdata0 unchanged.
- req0 and req1 asserted together, held high for two transactions -> fixed priority: ack0, ack0; with RAM_ARB_RR_EN: ack1 then ack0.
- req1 held while req0 served -> req1 served in next IDLE, no cycle with ram_ce=1 outside ACCESS, never both acks high.
- rst asserted during ACCESS of write 0x55 to 0x30 -> ram_ce/ram_we/busy low same cycle, no ack; after release req0 read works with 3-cycle latency.
- req0 pulsed one cycle while busy -> not served, no ack0.
